uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 156 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a byte FIFO.
// Queued bytes are sent back-to-back; pushes made while the FIFO is full are dropped and flagged.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned DEPTH_LOG2   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  output logic                  tx,
  output logic                  full,
  output logic                  empty,
  output logic                  busy,
  output logic                  overflow,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int unsigned            DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [15:0]            BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [DEPTH_LOG2-1:0]  PTR_ONE   = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]    LVL_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]    LVL_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state_q, state_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shift_q, shift_d;
  logic                   tx_q, tx_d;
  logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]    level_q, level_d;
  logic                   overflow_q, overflow_d;
  logic [7:0]             mem_q [DEPTH];

  logic push, pop, baud_done;

  assign full     = (level_q == LVL_FULL);
  assign empty    = (level_q == '0);
  assign busy     = (state_q != IDLE);
  assign tx       = tx_q;
  assign overflow = overflow_q;
  assign level    = level_q;

  assign baud_done = (cnt_q == BAUD_LAST);
  // Empty/full come from the registered level, so a byte pushed into an
  // empty FIFO cannot be popped on the same edge.
  assign push = wr_en && !full;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          state_d = START;
          cnt_d   = '0;
          bit_d   = '0;
          shift_d = mem_q[rd_ptr_q];
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_done) begin
          cnt_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (baud_done) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (baud_done) begin
          cnt_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            state_d = START;
            bit_d   = '0;
            shift_d = mem_q[rd_ptr_q];
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    overflow_d = overflow_q | (wr_en & full);
    level_d    = level_q;
    if (push && !pop)      level_d = level_q + LVL_ONE;
    else if (pop && !push) level_d = level_q - LVL_ONE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with CLKS_PER_BIT=4, DEPTH_LOG2=2.
// Each step checks tx cycle-by-cycle against a hand-derived 8N1 frame.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       tx, full, empty, busy, overflow;
  logic [2:0] level;

  int vectors = 0;
  int miscompares = 0;

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DEPTH_LOG2(2)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .tx(tx), .full(full), .empty(empty), .busy(busy),
    .overflow(overflow), .level(level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // k counts cycles since the start-bit edge; 4 cycles per bit.
  task automatic expect_frame(input logic [7:0] b, input int k0, input int k1, input string tag);
    logic e;
    for (int k = k0; k < k1; k++) begin
      if (k / 4 == 0)      e = 1'b0;
      else if (k / 4 == 9) e = 1'b1;
      else                 e = b[k / 4 - 1];
      chk($sformatf("%s tx k=%0d", tag, k), {31'd0, tx}, {31'd0, e});
      tick();
      wr_data = 8'($urandom);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
    tick(); tick();
    reset = 1'b1;
    chk("rst tx", {31'd0, tx}, 32'd1);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst empty", {31'd0, empty}, 32'd1);
    chk("rst full", {31'd0, full}, 32'd0);
    chk("rst level", {29'd0, level}, 32'd0);
    chk("rst overflow", {31'd0, overflow}, 32'd0);

    // single byte latency and bit order
    wr_en = 1'b1; wr_data = 8'h55;
    tick();
    wr_en = 1'b0;
    chk("t1 level", {29'd0, level}, 32'd1);
    chk("t1 empty", {31'd0, empty}, 32'd0);
    chk("t1 tx idle", {31'd0, tx}, 32'd1);
    chk("t1 busy idle", {31'd0, busy}, 32'd0);
    tick();
    chk("t1 busy", {31'd0, busy}, 32'd1);
    chk("t1 level pop", {29'd0, level}, 32'd0);
    expect_frame(8'h55, 0, 40, "t1");
    chk("t1 busy end", {31'd0, busy}, 32'd0);
    chk("t1 tx end", {31'd0, tx}, 32'd1);
    chk("t1 empty end", {31'd0, empty}, 32'd1);

    // three back-to-back frames
    wr_en = 1'b1; wr_data = 8'h41;
    tick();
    wr_data = 8'h42;
    tick();
    chk("t2 tx k=0", {31'd0, tx}, 32'd0);
    wr_data = 8'h43;
    tick();
    wr_en = 1'b0;
    chk("t2 level", {29'd0, level}, 32'd2);
    expect_frame(8'h41, 1, 40, "t2a");
    expect_frame(8'h42, 0, 40, "t2b");
    chk("t2 empty last pop", {31'd0, empty}, 32'd1);
    expect_frame(8'h43, 0, 40, "t2c");
    chk("t2 busy end", {31'd0, busy}, 32'd0);

    // overfill: 6 pushes, 6th dropped
    wr_en = 1'b1; wr_data = 8'h11;
    tick();
    wr_data = 8'h12;
    tick();
    chk("t3 tx k=0", {31'd0, tx}, 32'd0);
    wr_data = 8'h13;
    tick();
    chk("t3 level2", {29'd0, level}, 32'd2);
    wr_data = 8'h14;
    tick();
    chk("t3 level3", {29'd0, level}, 32'd3);
    wr_data = 8'h15;
    tick();
    chk("t3 level4", {29'd0, level}, 32'd4);
    chk("t3 full", {31'd0, full}, 32'd1);
    chk("t3 ovf before drop", {31'd0, overflow}, 32'd0);
    wr_data = 8'h16;
    tick();
    wr_en = 1'b0;
    chk("t3 level after drop", {29'd0, level}, 32'd4);
    chk("t3 overflow", {31'd0, overflow}, 32'd1);
    expect_frame(8'h11, 4, 40, "t3a");
    expect_frame(8'h12, 0, 40, "t3b");
    expect_frame(8'h13, 0, 40, "t3c");
    expect_frame(8'h14, 0, 40, "t3d");
    expect_frame(8'h15, 0, 40, "t3e");
    chk("t3 busy end", {31'd0, busy}, 32'd0);
    chk("t3 empty end", {31'd0, empty}, 32'd1);
    tick(); tick();
    chk("t3 no 6th frame", {31'd0, tx}, 32'd1);
    chk("t3 ovf sticky", {31'd0, overflow}, 32'd1);

    // push at full on the STOP->START pop edge is dropped
    do_reset();
    chk("t4 ovf cleared", {31'd0, overflow}, 32'd0);
    wr_en = 1'b1; wr_data = 8'h21;
    tick();
    wr_data = 8'h22;
    tick();
    wr_data = 8'h23;
    tick();
    wr_data = 8'h24;
    tick();
    wr_data = 8'h25;
    tick();
    wr_en = 1'b0;
    chk("t4 level4", {29'd0, level}, 32'd4);
    chk("t4 full", {31'd0, full}, 32'd1);
    expect_frame(8'h21, 3, 39, "t4a");
    chk("t4 stop tx", {31'd0, tx}, 32'd1);
    wr_en = 1'b1; wr_data = 8'h26;
    tick();
    wr_en = 1'b0;
    chk("t4 level3", {29'd0, level}, 32'd3);
    chk("t4 full clear", {31'd0, full}, 32'd0);
    chk("t4 overflow", {31'd0, overflow}, 32'd1);
    expect_frame(8'h22, 0, 40, "t4b");
    expect_frame(8'h23, 0, 40, "t4c");
    expect_frame(8'h24, 0, 40, "t4d");
    expect_frame(8'h25, 0, 40, "t4e");
    chk("t4 busy end", {31'd0, busy}, 32'd0);
    chk("t4 empty end", {31'd0, empty}, 32'd1);

    // reset during data bit 3, with wr_en held during reset
    do_reset();
    wr_en = 1'b1; wr_data = 8'hA5;
    tick();
    wr_data = 8'h01;
    tick();
    wr_data = 8'h02;
    tick();
    wr_en = 1'b0;
    chk("t5 level2", {29'd0, level}, 32'd2);
    expect_frame(8'hA5, 1, 18, "t5");
    reset = 1'b0; wr_en = 1'b1; wr_data = 8'h77;
    tick();
    chk("t5 tx", {31'd0, tx}, 32'd1);
    chk("t5 level", {29'd0, level}, 32'd0);
    chk("t5 busy", {31'd0, busy}, 32'd0);
    chk("t5 empty", {31'd0, empty}, 32'd1);
    chk("t5 overflow", {31'd0, overflow}, 32'd0);
    reset = 1'b1; wr_en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      chk($sformatf("t5 quiet tx %0d", i), {31'd0, tx}, 32'd1);
      tick();
    end
    chk("t5 busy quiet", {31'd0, busy}, 32'd0);

    // wr_data capture at push edge
    wr_en = 1'b1; wr_data = 8'h3C;
    tick();
    wr_en = 1'b0; wr_data = 8'hC3;
    tick();
    expect_frame(8'h3C, 0, 40, "t6");
    chk("t6 busy end", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
